led_pwm: RTL and testbench

- Downstream output stage for the board's four RGB LEDs: converts per-channel duty words into active-low PWM drive on led_rgb0..3.
- Counter and pattern logic upstream supplies a 12-channel duty vector through a valid/ready handshake.
- Duties are double-buffered and take effect only at a PWM period boundary, so LED waveforms never glitch.
- Runs on fpga_sysclk (100 MHz).

---
 rtl/led_pwm_pkg.sv | 24 ++
 rtl/led_pwm_ch.sv | 51 +++++
 rtl/led_pwm.sv | 91 +++++++++
 tb/tb_led_pwm.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared constants, channel indexing and gamma curve for the LED PWM stage.
// Gamma is only used when LED_PWM_GAMMA_EN is defined.
package led_pkg;
    localparam int NUM_LEDS = 4;
    localparam int NUM_CH   = 3;
    localparam int NUM_CHAN = NUM_LEDS * NUM_CH;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_e;

    function automatic int ch_off(input int led, input ch_e ch, input int w);
        return (led * NUM_CH + int'(ch)) * w;
    endfunction

    // (d*d + 2^w-1) >> w, evaluated at 2*w bits; valid for w <= 16.
    function automatic logic [31:0] gamma(input logic [15:0] d, input int w);
        logic [31:0] sq;
        sq = 32'(d) * 32'(d) + ((32'd1 << w) - 32'd1);
        return sq >> w;
    endfunction
endpackage

// File: rtl/led_pwm_ch.sv
// One PWM channel: active duty register, comparator and output flop.
// With LED_PWM_GAMMA_EN a gamma stage tracks the pending word ahead of commit.
module led_pwm_ch
    import led_pkg::*;
#(
    parameter int DUTY_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DUTY_W-1:0] phase_i,
    input  logic              commit_i,
    input  logic [DUTY_W-1:0] src_i,
    output logic              led_o
);
    logic [DUTY_W-1:0] act_q, act_d;
    logic              led_q, led_d;

    assign led_d = !(phase_i < act_q);
    assign led_o = led_q;

`ifdef LED_PWM_GAMMA_EN
    // src_i is the pending next-state, so gam_q always equals gamma(pending).
    logic [DUTY_W-1:0] gam_q, gam_d;
    assign gam_d = DUTY_W'(gamma(16'(src_i), DUTY_W));
    assign act_d = commit_i ? gam_q : act_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gam_q <= '0;
            act_q <= '0;
            led_q <= 1'b1;
        end else begin
            gam_q <= gam_d;
            act_q <= act_d;
            led_q <= led_d;
        end
    end
`else
    assign act_d = commit_i ? src_i : act_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            act_q <= '0;
            led_q <= 1'b1;
        end else begin
            act_q <= act_d;
            led_q <= led_d;
        end
    end
`endif
endmodule

// File: rtl/led_pwm.sv
// Active-low RGB LED PWM with double-buffered duties committed at period start.
// Optional gamma correction via LED_PWM_GAMMA_EN.
module led_pwm
    import led_pkg::*;
#(
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 390
) (
    input  logic                       fpga_sysclk,
    input  logic                       rst_fpga_,
    input  logic [NUM_CHAN*DUTY_W-1:0] in_duty,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [2:0]                 led_rgb0,
    output logic [2:0]                 led_rgb1,
    output logic [2:0]                 led_rgb2,
    output logic [2:0]                 led_rgb3,
    output logic                       frame_strobe
);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] PH_LAST  = DUTY_W'((1 << DUTY_W) - 2);

    logic [PW-1:0]              pre_q, pre_d;
    logic [DUTY_W-1:0]          ph_q, ph_d;
    logic [NUM_CHAN*DUTY_W-1:0] pend_q, pend_d, src_v;
    logic                       full_q, full_d;
    logic                       strb_q;
    logic                       tick, bnd, xfer, commit;
    logic [NUM_CHAN-1:0]        led_v;

    assign tick   = (pre_q == PRE_LAST);
    assign bnd    = tick && (ph_q == PH_LAST);
    assign xfer   = in_valid && !full_q;
    assign commit = bnd && full_q;

    always_comb begin
        pre_d  = tick ? '0 : pre_q + PW'(1);
        ph_d   = ph_q;
        if (tick) ph_d = bnd ? '0 : ph_q + DUTY_W'(1);
        pend_d = xfer ? in_duty : pend_q;
        full_d = full_q;
        // Accept only when empty, so a boundary never races a capture.
        if (xfer)     full_d = 1'b1;
        else if (bnd) full_d = 1'b0;
    end

    always_ff @(posedge fpga_sysclk) begin
        if (!rst_fpga_) begin
            pre_q  <= '0;
            ph_q   <= '0;
            pend_q <= '0;
            full_q <= 1'b0;
            strb_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ph_q   <= ph_d;
            pend_q <= pend_d;
            full_q <= full_d;
            strb_q <= bnd;
        end
    end

    assign in_ready     = !full_q;
    assign frame_strobe = strb_q;

`ifdef LED_PWM_GAMMA_EN
    assign src_v = pend_d;
`else
    assign src_v = pend_q;
`endif

    for (genvar l = 0; l < NUM_LEDS; l++) begin : g_led
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            localparam int OFF = ch_off(l, ch_e'(c), DUTY_W);
            led_pwm_ch #(.DUTY_W(DUTY_W)) u_ch (
                .clk_i    (fpga_sysclk),
                .rst_ni   (rst_fpga_),
                .phase_i  (ph_q),
                .commit_i (commit),
                .src_i    (src_v[OFF +: DUTY_W]),
                .led_o    (led_v[l*NUM_CH + c])
            );
        end
    end

    assign led_rgb0 = led_v[2:0];
    assign led_rgb1 = led_v[5:3];
    assign led_rgb2 = led_v[8:6];
    assign led_rgb3 = led_v[11:9];
endmodule

// File: tb/tb_led_pwm.sv
// Directed bench for led_pwm at DUTY_W=4, PRESCALE=2 (30-clock period);
// expected per-channel on-times are queued when words are driven.
module tb_led_pwm;
    localparam int DW  = 4;
    localparam int PS  = 2;
    localparam int NCH = 12;
    localparam int PER = 30;

    typedef logic [NCH-1:0][7:0] cnt_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [NCH*DW-1:0] in_duty = '0;
    logic              in_ready, strobe;
    logic [2:0]        r0, r1, r2, r3;
    logic [NCH-1:0]    leds;

    int   checks = 0;
    int   failures = 0;
    cnt_t exp_q[$];

    always #5 clk = ~clk;

    led_pwm #(.DUTY_W(DW), .PRESCALE(PS)) dut (
        .fpga_sysclk  (clk),
        .rst_fpga_    (rst_n),
        .in_duty      (in_duty),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .led_rgb0     (r0),
        .led_rgb1     (r1),
        .led_rgb2     (r2),
        .led_rgb3     (r3),
        .frame_strobe (strobe)
    );

    assign leds = {r3, r2, r1, r0};

    function automatic int eff(input int d);
`ifdef LED_PWM_GAMMA_EN
        return (d * d + 15) >> 4;
`else
        return d;
`endif
    endfunction

    function automatic cnt_t exp_of(input logic [NCH*DW-1:0] w);
        cnt_t r;
        for (int k = 0; k < NCH; k++) r[k] = 8'(eff(int'(w[k*DW +: DW])) * PS);
        return r;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2*PER + 5 && !seen; i++) begin
            @(negedge clk);
            if (strobe) seen = 1'b1;
        end
        chk({tag, "_strobe_seen"}, int'(seen), 1);
    endtask

    // Window starts at the current sample and ends on the next strobe sample.
    task automatic measure(input string tag);
        cnt_t got = '0;
        cnt_t exp;
        int   nstb = 0;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge clk);
            for (int k = 0; k < NCH; k++)
                if (leds[k] === 1'b0) got[k] = got[k] + 8'd1;
            if (strobe) nstb++;
        end
        chk({tag, "_strobes"}, nstb, 1);
        chk({tag, "_strobe_at_end"}, int'(strobe), 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_exp_avail"}, 0, 1);
        end else begin
            exp = exp_q.pop_front();
            for (int k = 0; k < NCH; k++)
                chk($sformatf("%s_ch%0d", tag, k), int'(got[k]), int'(exp[k]));
        end
    endtask

    initial begin
        logic [NCH*DW-1:0] w1, wa, wb, wc, wd;
        bit stall_ok;
        int n;

        w1 = '0; w1[0*DW +: DW] = 4'd5; w1[1*DW +: DW] = 4'd15;
        wa = '0; wa[3*DW +: DW] = 4'd8; wa[6*DW +: DW] = 4'd1; wa[11*DW +: DW] = 4'd15;
        wb = '0; wb[0*DW +: DW] = 4'd8; wb[2*DW +: DW] = 4'd3;
        wb[5*DW +: DW] = 4'd7; wb[9*DW +: DW] = 4'd14;
        wc = '0; wc[4*DW +: DW] = 4'd12; wc[7*DW +: DW] = 4'd2; wc[10*DW +: DW] = 4'd9;
        wd = '1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_leds", int'(leds), 12'hFFF);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_strobe", int'(strobe), 0);

        // idle: no light, 30-clock frame
        rst_n = 1'b1;
        exp_q.push_back(exp_of('0));
        wait_strobe("idle");
        @(negedge clk);
        measure("idle");

        // single load
        in_duty = w1; in_valid = 1'b1;
        exp_q.push_back(exp_of(w1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("load_ready_low", int'(in_ready), 0);
        wait_strobe("load");
        chk("load_ready_back", int'(in_ready), 1);
        @(negedge clk);
        measure("load");

        // back-to-back words: second stalls until the boundary
        in_duty = wa; in_valid = 1'b1;
        @(negedge clk);
        in_duty = wb;
        stall_ok = 1'b1;
        n = 0;
        while (!strobe && n < 2*PER) begin
            if (in_ready) stall_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("b2b_strobe", int'(strobe), 1);
        chk("b2b_stalled", int'(stall_ok), 1);
        chk("b2b_ready_at_bnd", int'(in_ready), 1);
        exp_q.push_back(exp_of(wa));
        exp_q.push_back(exp_of(wb));
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_taken", int'(in_ready), 0);
        measure("b2b_a");
        @(negedge clk);
        measure("b2b_b");

        // transfer on the boundary edge lands in pending, not active
        repeat (PER-1) @(negedge clk);
        in_duty = wc; in_valid = 1'b1;
        @(negedge clk);
        chk("bnd_strobe", int'(strobe), 1);
        chk("bnd_captured", int'(in_ready), 0);
        in_valid = 1'b0;
        exp_q.push_back(exp_of(wb));
        exp_q.push_back(exp_of(wc));
        @(negedge clk);
        measure("bnd_old");
        @(negedge clk);
        measure("bnd_new");

        // reset mid-period with pending full
        in_duty = wd; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_pend_full", int'(in_ready), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_leds", int'(leds), 12'hFFF);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_strobe", int'(strobe), 0);
        rst_n = 1'b1;
        exp_q.push_back(exp_of('0));
        wait_strobe("post_rst");
        @(negedge clk);
        measure("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
